eu_iqueue: RTL and testbench



---
 rtl/eu_iqueue.sv | 131 +++++++++++++
 tb/tb_eu_iqueue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eu_iqueue.sv
// Instruction types shared by dispatch and the exec units, followed by the
// per-exec-unit in-order issue queue with compare-flag hazard hold.
package pkg_dtypes;

  typedef enum logic [1:0] {
    EXEC_UNIT     = 2'd0,
    EXEC_UNIT_CMP = 2'd1,
    LDR_STR       = 2'd2,
    BRANCH        = 2'd3
  } type_exec;

  typedef struct packed {
    type_exec   exec_type;
    logic [3:0] op;
  } type_opcode;

  typedef struct packed {
    logic [7:0] spec;
    logic [3:0] rd;
  } type_operand;

  typedef struct packed {
    type_opcode  opcode;
    type_operand opd;
  } type_iqueue_entry;

endpackage

module eu_iqueue
  import pkg_dtypes::*;
#(
  parameter int LOG2_DEPTH = 3
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic                          i_flush,
  input  logic                          i_enq_valid,
  output logic                          o_enq_ready,
  input  logic [$bits(type_iqueue_entry)-1:0] i_enq_entry,
  output logic                          o_deq_valid,
  input  logic                          i_deq_ready,
  output logic [$bits(type_iqueue_entry)-1:0] o_deq_entry,
  input  logic                          i_cmp_done,
  output logic [LOG2_DEPTH:0]           o_count,
  output logic                          o_full,
  output logic                          o_empty,
  output logic                          o_err_illegal
);

  localparam int DEPTH = 2 ** LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] DEPTH_CNT = (LOG2_DEPTH + 1)'(DEPTH);

  type_iqueue_entry        r_mem [DEPTH];
  logic [LOG2_DEPTH-1:0]   r_rd_ptr;
  logic [LOG2_DEPTH-1:0]   r_wr_ptr;
  logic [LOG2_DEPTH:0]     r_count;
  logic                    r_cmp_pending;
  logic                    r_err_illegal;

  type_iqueue_entry        w_enq_entry;
  type_iqueue_entry        w_head;
  logic                    w_enq_legal;
  logic                    w_enq_fire;
  logic                    w_store;
  logic                    w_deq_fire;
  logic                    w_head_cmp;

  assign w_enq_entry = type_iqueue_entry'(i_enq_entry);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_cmp  = (w_head.opcode.exec_type == EXEC_UNIT_CMP);
  assign w_enq_legal = (w_enq_entry.opcode.exec_type == EXEC_UNIT) ||
                       (w_enq_entry.opcode.exec_type == EXEC_UNIT_CMP);

  assign o_full      = (r_count == DEPTH_CNT);
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign o_enq_ready = !o_full;
  assign o_deq_valid = !o_empty && !(w_head_cmp && r_cmp_pending);
  assign o_deq_entry = w_head;
  assign o_err_illegal = r_err_illegal;

  // A flush cycle still handshakes on the ports but nothing takes effect.
  assign w_enq_fire = i_enq_valid && o_enq_ready && !i_flush;
  assign w_store    = w_enq_fire && w_enq_legal;
  assign w_deq_fire = o_deq_valid && i_deq_ready && !i_flush;

  always_ff @(posedge i_clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= w_enq_entry;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_err_illegal <= 1'b0;
    end else if (i_flush) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_err_illegal <= 1'b0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_deq_fire) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_store && !w_deq_fire) begin
        r_count <= r_count + 1'b1;
      end else if (!w_store && w_deq_fire) begin
        r_count <= r_count - 1'b1;
      end
      r_err_illegal <= w_enq_fire && !w_enq_legal;
    end
  end

  // The in-flight compare survives a flush, so only reset clears the hazard.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_cmp_pending <= 1'b0;
    end else if (w_deq_fire && w_head_cmp) begin
      r_cmp_pending <= 1'b1;
    end else if (i_cmp_done) begin
      r_cmp_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eu_iqueue.sv
// Self-checking bench for eu_iqueue: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_eu_iqueue;
  import pkg_dtypes::*;

  localparam int LOG2_DEPTH = 3;
  localparam int DEPTH      = 8;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             flush = 1'b0;
  logic             enq_valid = 1'b0;
  logic             deq_ready = 1'b0;
  logic             cmp_done = 1'b0;
  type_iqueue_entry enq_entry = '0;
  type_iqueue_entry deq_entry;
  logic [$bits(type_iqueue_entry)-1:0] deq_bits;
  logic             enq_ready, deq_valid, full, empty, err;
  logic [LOG2_DEPTH:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  type_iqueue_entry m_q[$];
  bit m_cmp = 1'b0;
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  assign deq_entry = type_iqueue_entry'(deq_bits);

  eu_iqueue #(.LOG2_DEPTH(LOG2_DEPTH)) dut (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .i_flush      (flush),
    .i_enq_valid  (enq_valid),
    .o_enq_ready  (enq_ready),
    .i_enq_entry  (enq_entry),
    .o_deq_valid  (deq_valid),
    .i_deq_ready  (deq_ready),
    .o_deq_entry  (deq_bits),
    .i_cmp_done   (cmp_done),
    .o_count      (count),
    .o_full       (full),
    .o_empty      (empty),
    .o_err_illegal(err)
  );

  function automatic type_iqueue_entry mk(type_exec t, int spec);
    type_iqueue_entry e;
    e = '0;
    e.opcode.exec_type = t;
    e.opcode.op        = 4'(spec);
    e.opd.spec         = 8'(spec);
    e.opd.rd           = 4'(spec >> 2);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_deq_valid();
    if (m_q.size() == 0) return 1'b0;
    return !(m_q[0].opcode.exec_type == EXEC_UNIT_CMP && m_cmp);
  endfunction

  task automatic check_model();
    chk("count", 32'(count), 32'(m_q.size()));
    chk("full", 32'(full), 32'(m_q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(m_q.size() == 0));
    chk("enq_ready", 32'(enq_ready), 32'(m_q.size() < DEPTH));
    chk("deq_valid", 32'(deq_valid), 32'(model_deq_valid()));
    chk("err_illegal", 32'(err), 32'(m_err));
    if (m_q.size() > 0) chk("deq_entry", 32'(deq_entry), 32'(m_q[0]));
  endtask

  task automatic model_step();
    bit ef, df, legal, setc;
    if (!nrst) begin
      m_q.delete(); m_cmp = 1'b0; m_err = 1'b0;
      return;
    end
    ef    = enq_valid && (m_q.size() < DEPTH);
    df    = model_deq_valid() && deq_ready;
    legal = (enq_entry.opcode.exec_type == EXEC_UNIT) ||
            (enq_entry.opcode.exec_type == EXEC_UNIT_CMP);
    if (flush) begin
      m_q.delete();
      m_err = 1'b0;
      if (cmp_done) m_cmp = 1'b0;
    end else begin
      setc = df && (m_q[0].opcode.exec_type == EXEC_UNIT_CMP);
      if (df) void'(m_q.pop_front());
      if (ef && legal) m_q.push_back(enq_entry);
      m_err = ef && !legal;
      if (setc) m_cmp = 1'b1;
      else if (cmp_done) m_cmp = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_enq_ready"}, 32'(enq_ready), 32'd1);
    chk({tag, "_deq_valid"}, 32'(deq_valid), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic enq(input type_iqueue_entry e);
    enq_valid = 1'b1;
    enq_entry = e;
    cycle();
    enq_valid = 1'b0;
  endtask

  initial begin
    #12;
    reset_vals("por");
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // fill to DEPTH, then an attempted enqueue while full is refused
    for (int i = 0; i < DEPTH; i++) enq(mk(EXEC_UNIT, i));
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(enq_ready), 32'd0);
    enq(mk(EXEC_UNIT, 99));
    chk("full_no_store", 32'(count), 32'd8);

    deq_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_valid", 32'(deq_valid), 32'd1);
      chk("drain_order", 32'(deq_entry.opd.spec), 32'(i));
      cycle();
    end
    chk("drain_empty", 32'(empty), 32'd1);
    deq_ready = 1'b0;

    // steady-state streaming at depth 3 across pointer wrap
    for (int i = 0; i < 3; i++) enq(mk(EXEC_UNIT, 100 + i));
    deq_ready = 1'b1;
    enq_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      enq_entry = mk(EXEC_UNIT, 103 + k);
      chk("wrap_order", 32'(deq_entry.opd.spec), 32'(100 + k));
      cycle();
      chk("wrap_count", 32'(count), 32'd3);
    end
    enq_valid = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    chk("wrap_empty", 32'(empty), 32'd1);
    deq_ready = 1'b0;

    // illegal opcode is consumed but dropped
    chk("ill_ready", 32'(enq_ready), 32'd1);
    enq(mk(LDR_STR, 50));
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_count", 32'(count), 32'd0);
    enq(mk(EXEC_UNIT, 51));
    chk("ill_err_pulse", 32'(err), 32'd0);
    chk("ill_add_count", 32'(count), 32'd1);
    deq_ready = 1'b1;
    cycle();
    deq_ready = 1'b0;
    chk("ill_empty", 32'(empty), 32'd1);

    // compare hazard
    enq(mk(EXEC_UNIT_CMP, 1));
    enq(mk(EXEC_UNIT_CMP, 2));
    enq(mk(EXEC_UNIT, 3));
    deq_ready = 1'b1;
    chk("cmp1_valid", 32'(deq_valid), 32'd1);
    chk("cmp1_head", 32'(deq_entry.opd.spec), 32'd1);
    cycle();
    for (int k = 0; k < 3; k++) begin
      chk("cmp_blocked", 32'(deq_valid), 32'd0);
      chk("cmp_blocked_cnt", 32'(count), 32'd2);
      cycle();
    end
    cmp_done = 1'b1;
    cycle();
    cmp_done = 1'b0;
    chk("cmp2_valid", 32'(deq_valid), 32'd1);
    chk("cmp2_head", 32'(deq_entry.opd.spec), 32'd2);
    cmp_done = 1'b1;
    cycle();
    cmp_done = 1'b0;
    chk("add_valid", 32'(deq_valid), 32'd1);
    chk("add_head", 32'(deq_entry.opd.spec), 32'd3);
    cycle();
    deq_ready = 1'b0;
    enq(mk(EXEC_UNIT_CMP, 4));
    chk("set_wins", 32'(deq_valid), 32'd0);

    // flush with coincident traffic; hazard survives
    for (int i = 5; i < 9; i++) enq(mk(EXEC_UNIT, i));
    chk("pre_flush_cnt", 32'(count), 32'd5);
    flush = 1'b1; enq_valid = 1'b1; deq_ready = 1'b1;
    enq_entry = mk(EXEC_UNIT, 9);
    cycle();
    flush = 1'b0; enq_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_err", 32'(err), 32'd0);
    enq(mk(EXEC_UNIT_CMP, 10));
    chk("flush_keeps_cmp", 32'(deq_valid), 32'd0);
    for (int i = 11; i < 14; i++) enq(mk(EXEC_UNIT, i));
    chk("pre_rst_count", 32'(count), 32'd4);
    chk("pre_rst_block", 32'(deq_valid), 32'd0);

    // asynchronous reset mid-cycle
    #2;
    nrst = 1'b0;
    #1;
    reset_vals("arst");
    m_q.delete(); m_cmp = 1'b0; m_err = 1'b0;
    deq_ready = 1'b0;
    @(negedge clk);
    #2;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    reset_vals("post_rst");

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int r;
      enq_valid = ($urandom_range(0, 99) < 60);
      deq_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 3);
      cmp_done  = ($urandom_range(0, 99) < 25);
      r = int'($urandom_range(0, 9));
      enq_entry = mk(r < 5 ? EXEC_UNIT : r < 8 ? EXEC_UNIT_CMP : r == 8 ? LDR_STR : BRANCH,
                     int'($urandom_range(0, 255)));
      cycle();
    end
    enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0; cmp_done = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
